cr16_regfile_reader: RTL and testbench

- Read-back sequencer for the CR16 datapath register file; the reader counterpart to the Fibonacci write FSM.
- On a start pulse it steps read port A select through r0..r(NUM_REGS-1) and samples each value.
- Each value is checked against the Fibonacci sequence 1,1,2,3,5,… and pass/fail, first-mismatch index and mismatch count are latched.
- After the scan, a review mode lets a board button step through registers for 7-segment display.

---
 rtl/cr16_regfile_reader.sv | 131 +++++++++++++
 tb/tb_cr16_regfile_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_regfile_reader.sv
// Read-back sequencer for the CR16 register file: scans r0..r(NUM_REGS-1) through read port A,
// checks each value against the Fibonacci sequence and offers a stepped review mode afterwards.
module cr16_regfile_reader #(
  parameter int NUM_REGS      = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_START,
  input  logic        I_STEP,
  input  logic [15:0] I_READ_DATA,
  output logic [3:0]  O_READ_SEL,
  output logic [15:0] O_VALUE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_PASS,
  output logic        O_FAIL,
  output logic [3:0]  O_MISMATCH_INDEX,
  output logic [4:0]  O_MISMATCH_COUNT
);

  localparam logic [3:0] LAST_IDX    = 4'(NUM_REGS - 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  index_r;
  logic [3:0]  settle_cnt_r;
  logic [15:0] cur_r;
  logic [15:0] next_r;
  logic        start_ok_s;
  logic        mismatch_s;

  // Next Fibonacci term, wrapping modulo 2^16
  function automatic logic [15:0] fib_next(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  // Start acceptance and sample comparison
  always_comb begin
    start_ok_s = I_START && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    mismatch_s = (I_READ_DATA != cur_r);
  end

  // Scan sequencer with all outputs registered
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_r          <= ST_IDLE;
      index_r          <= 4'd0;
      settle_cnt_r     <= 4'd0;
      cur_r            <= 16'd1;
      next_r           <= 16'd1;
      O_READ_SEL       <= 4'd0;
      O_VALUE          <= 16'd0;
      O_BUSY           <= 1'b0;
      O_DONE           <= 1'b0;
      O_PASS           <= 1'b0;
      O_FAIL           <= 1'b0;
      O_MISMATCH_INDEX <= 4'd0;
      O_MISMATCH_COUNT <= 5'd0;
    end else if (start_ok_s) begin
      // A start in DONE takes priority over a simultaneous step
      state_r          <= ST_SETTLE;
      index_r          <= 4'd0;
      settle_cnt_r     <= SETTLE_INIT;
      cur_r            <= 16'd1;
      next_r           <= 16'd1;
      O_READ_SEL       <= 4'd0;
      O_VALUE          <= 16'd0;
      O_BUSY           <= 1'b1;
      O_DONE           <= 1'b0;
      O_PASS           <= 1'b0;
      O_FAIL           <= 1'b0;
      O_MISMATCH_INDEX <= 4'd0;
      O_MISMATCH_COUNT <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_r == 4'd0) begin
            state_r <= ST_SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_SAMPLE: begin
          O_VALUE <= I_READ_DATA;
          if (mismatch_s) begin
            O_MISMATCH_COUNT <= O_MISMATCH_COUNT + 5'd1;
            if (!O_FAIL) begin
              O_FAIL           <= 1'b1;
              O_MISMATCH_INDEX <= index_r;
            end
          end
          if (index_r == LAST_IDX) begin
            state_r <= ST_DONE;
            O_BUSY  <= 1'b0;
            O_DONE  <= 1'b1;
            O_PASS  <= ~(O_FAIL | mismatch_s);
          end else begin
            state_r      <= ST_SETTLE;
            index_r      <= index_r + 4'd1;
            O_READ_SEL   <= index_r + 4'd1;
            settle_cnt_r <= SETTLE_INIT;
            cur_r        <= next_r;
            next_r       <= fib_next(cur_r, next_r);
          end
        end
        ST_DONE: begin
          // Review mode: value trails the select by one cycle
          O_VALUE <= I_READ_DATA;
          if (I_STEP) begin
            O_READ_SEL <= (O_READ_SEL == LAST_IDX) ? 4'd0 : O_READ_SEL + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr16_regfile_reader.sv
// Scoreboard bench for cr16_regfile_reader: a default instance (8 regs, settle 1) and a
// 16-register instance (settle 2), each answered by a register-file array in the bench.
module tb_cr16_regfile_reader;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [3:0]  idx;
    logic [4:0]  cnt;
    logic [15:0] value;
    logic [3:0]  sel;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic        start8, step8, start16, step16;
  logic [15:0] mem8 [16];
  logic [15:0] mem16[16];
  logic [15:0] fib_ref[16];
  logic [15:0] rd8, rd16;
  logic [3:0]  sel8, sel16, idx8, idx16;
  logic [15:0] value8, value16;
  logic        busy8, busy16, done8, done16, pass8, pass16, fail8, fail16;
  logic [4:0]  cnt8, cnt16;
  logic        prev8 = 1'b0;
  logic        prev16 = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q8[$];
  exp_t        q16[$];

  assign rd8  = mem8[sel8];
  assign rd16 = mem16[sel16];

  cr16_regfile_reader dut8 (
    .I_CLK(clk), .I_NRESET(nreset), .I_START(start8), .I_STEP(step8), .I_READ_DATA(rd8),
    .O_READ_SEL(sel8), .O_VALUE(value8), .O_BUSY(busy8), .O_DONE(done8), .O_PASS(pass8),
    .O_FAIL(fail8), .O_MISMATCH_INDEX(idx8), .O_MISMATCH_COUNT(cnt8)
  );

  cr16_regfile_reader #(.NUM_REGS(16), .SETTLE_CYCLES(2)) dut16 (
    .I_CLK(clk), .I_NRESET(nreset), .I_START(start16), .I_STEP(step16), .I_READ_DATA(rd16),
    .O_READ_SEL(sel16), .O_VALUE(value16), .O_BUSY(busy16), .O_DONE(done16), .O_PASS(pass16),
    .O_FAIL(fail16), .O_MISMATCH_INDEX(idx16), .O_MISMATCH_COUNT(cnt16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference: register i must hold the i-th Fibonacci term; first miss, miss count, last value
  function automatic exp_t model(input bit big);
    exp_t e;
    int n;
    logic [15:0] d;
    n = big ? 16 : 8;
    e.fail = 1'b0; e.idx = 4'd0; e.cnt = 5'd0; e.value = 16'd0;
    for (int i = 0; i < n; i++) begin
      d = big ? mem16[i] : mem8[i];
      if (d != fib_ref[i]) begin
        if (!e.fail) e.idx = 4'(i);
        e.fail = 1'b1;
        e.cnt = e.cnt + 5'd1;
      end
      e.value = d;
    end
    e.pass = !e.fail;
    e.sel = 4'(n - 1);
    e.lat = big ? n * (2 + 2) : n * (1 + 2);
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic score(input bit big);
    exp_t  e;
    string nm;
    nm = big ? "dut16" : "dut8";
    if ((big ? q16.size() : q8.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_unexpected_done: got done=1 required no pending scan", nm);
      return;
    end
    if (big) e = q16.pop_front();
    else     e = q8.pop_front();
    chk({nm, "_latency"}, cyc - e.start_cyc - 1, e.lat);
    chk({nm, "_pass"},  big ? pass16  : pass8,  e.pass);
    chk({nm, "_fail"},  big ? fail16  : fail8,  e.fail);
    chk({nm, "_index"}, big ? idx16   : idx8,   e.idx);
    chk({nm, "_count"}, big ? cnt16   : cnt8,   e.cnt);
    chk({nm, "_value"}, big ? value16 : value8, e.value);
    chk({nm, "_sel"},   big ? sel16   : sel8,   e.sel);
    chk({nm, "_busy"},  big ? busy16  : busy8,  0);
  endtask

  // Monitors: score each rising edge of DONE against the oldest pending expectation
  always @(negedge clk) begin
    prev8  <= done8;
    prev16 <= done16;
    if (nreset && done8 && !prev8) score(1'b0);
    if (nreset && done16 && !prev16) score(1'b1);
  end

  task automatic load_fib(input bit big);
    for (int i = 0; i < 16; i++) begin
      if (big) mem16[i] = fib_ref[i];
      else     mem8[i]  = fib_ref[i];
    end
  endtask

  task automatic random_mem(input bit big);
    logic [15:0] flip;
    load_fib(big);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        flip = 16'($urandom_range(1, 65535));
        if (big) mem16[i] = mem16[i] ^ flip;
        else     mem8[i]  = mem8[i] ^ flip;
      end
    end
  endtask

  // Push the expectation and pulse start for one cycle (called at a negedge)
  task automatic issue(input bit big);
    exp_t e;
    e = model(big);
    e.start_cyc = cyc;
    if (big) begin q16.push_back(e); start16 = 1'b1; end
    else     begin q8.push_back(e);  start8  = 1'b1; end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q8.size() != 0 || q16.size() != 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      chk("done_timeout_pending", q8.size() + q16.size(), 0);
      q8.delete();
      q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   sel8,   0);
    chk({tag, "_value"}, value8, 0);
    chk({tag, "_busy"},  busy8,  0);
    chk({tag, "_done"},  done8,  0);
    chk({tag, "_pass"},  pass8,  0);
    chk({tag, "_fail"},  fail8,  0);
    chk({tag, "_index"}, idx8,   0);
    chk({tag, "_count"}, cnt8,   0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    start8 = 1'b0; step8 = 1'b0; start16 = 1'b0; step16 = 1'b0;
    fib_ref[0] = 16'd1;
    fib_ref[1] = 16'd1;
    for (int i = 2; i < 16; i++) fib_ref[i] = fib_ref[i-1] + fib_ref[i-2];
    load_fib(1'b0);
    load_fib(1'b1);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    nreset = 1'b1;
    @(negedge clk);

    // Clean Fibonacci scan
    issue(1'b0);
    chk("scan_busy", busy8, 1);
    chk("scan_sel0", sel8, 0);
    drain();

    // Single bad register r5
    mem8[5] = 16'd9;
    issue(1'b0);
    drain();

    // Two bad registers, then a clean rescan clears the flags
    load_fib(1'b0);
    mem8[2] = 16'd0;
    mem8[6] = 16'hFFFF;
    issue(1'b0);
    drain();
    load_fib(1'b0);
    issue(1'b0);
    drain();

    // Start and step during a scan are ignored
    issue(1'b0);
    repeat (3) @(negedge clk);
    start8 = 1'b1; step8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; step8 = 1'b0;
    drain();

    // Review mode: three steps wrap 7 -> 0 -> 1 -> 2
    for (int k = 0; k < 3; k++) begin
      step8 = 1'b1;
      @(negedge clk);
      step8 = 1'b0;
    end
    chk("review_sel", sel8, 2);
    @(negedge clk);
    chk("review_value", value8, 2);

    // Start together with step restarts the scan
    step8 = 1'b1;
    issue(1'b0);
    step8 = 1'b0;
    chk("restart_sel", sel8, 0);
    chk("restart_busy", busy8, 1);
    chk("restart_done", done8, 0);
    drain();

    // Reset in the middle of a scan
    issue(1'b0);
    repeat (9) @(negedge clk);
    q8.delete();
    nreset = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Randomised corruption on the 8-register instance
    for (int k = 0; k < 6; k++) begin
      random_mem(1'b0);
      issue(1'b0);
      drain();
    end

    // 16-register instance: clean scan, then randomised corruption
    load_fib(1'b1);
    issue(1'b1);
    drain();
    for (int k = 0; k < 3; k++) begin
      random_mem(1'b1);
      issue(1'b1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
